// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX operand bundle into the multiply/divide unit and the
// tagged result bundle out of it. The master side is the pipeline (ID/EX
// register plus EX/MEM consumer); the slave side is ex_muldiv.
interface ex_muldiv_if;
    logic [5:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        stall_req_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  wd_o;
    logic        wreg_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  stall_req_o, valid_o, result_o, wd_o, wreg_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
        output stall_req_o, valid_o, result_o, wd_o, wreg_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit sitting after ID/EX.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle on operand magnitudes, with a sign fixup on the last iteration.
// Divide-by-zero and signed overflow bypass the iteration.
// Optional macro MULDIV_FAST_MUL_EN: MUL* ops finish in one cycle using a
// single-cycle multiplier; division stays iterative.
module ex_muldiv #(
    parameter logic [5:0] OP_MUL    = 6'd40,
    parameter logic [5:0] OP_MULH   = 6'd41,
    parameter logic [5:0] OP_MULHSU = 6'd42,
    parameter logic [5:0] OP_MULHU  = 6'd43,
    parameter logic [5:0] OP_DIV    = 6'd44,
    parameter logic [5:0] OP_DIVU   = 6'd45,
    parameter logic [5:0] OP_REM    = 6'd46,
    parameter logic [5:0] OP_REMU   = 6'd47
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     flush_i,
    ex_muldiv_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [5:0]  r_op;
    logic [4:0]  r_wd;
    logic        r_wreg;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_opd;     // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [63:0] r_acc;     // {hi, multiplier} for mul, {remainder, dividend/quotient} for div
    logic        r_valid;
    logic [31:0] r_result;
    logic [4:0]  r_wd_o;
    logic        r_wreg_o;

    logic        w_is_m, w_is_mul, w_sgn_a, w_sgn_b;
    logic [31:0] w_mag_a, w_mag_b;
    logic        w_div0, w_ovf, w_fast_mul, w_fast;
    logic [31:0] w_fast_res;
    logic        w_busy_mul;
    logic [32:0] w_mul_sum, w_rem_sh, w_trial;
    logic [63:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod_fix;
    logic [31:0] w_quo_fix, w_rem_fix, w_final;
    logic        w_stall;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
`endif

    // Decode the incoming aluop: operand signs, magnitudes and single-cycle shortcuts.
    always_comb begin
        w_is_m   = (bus.aluop_i >= OP_MUL) && (bus.aluop_i <= OP_REMU);
        w_is_mul = w_is_m && (bus.aluop_i <= OP_MULHU);
        w_sgn_a  = ((bus.aluop_i == OP_MULH) || (bus.aluop_i == OP_MULHSU) ||
                    (bus.aluop_i == OP_DIV)  || (bus.aluop_i == OP_REM)) && bus.reg1_i[31];
        w_sgn_b  = ((bus.aluop_i == OP_MULH) || (bus.aluop_i == OP_DIV) ||
                    (bus.aluop_i == OP_REM)) && bus.reg2_i[31];
        w_mag_a  = w_sgn_a ? (32'd0 - bus.reg1_i) : bus.reg1_i;
        w_mag_b  = w_sgn_b ? (32'd0 - bus.reg2_i) : bus.reg2_i;
        w_div0   = w_is_m && !w_is_mul && (bus.reg2_i == 32'd0);
        w_ovf    = ((bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_REM)) &&
                   (bus.reg1_i == 32'h8000_0000) && (bus.reg2_i == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
        w_fast_prod = 64'($signed({w_sgn_a, bus.reg1_i})) * 64'($signed({w_sgn_b, bus.reg2_i}));
        w_fast_mul  = w_is_mul;
`else
        w_fast_mul  = 1'b0;
`endif
        w_fast     = w_div0 || w_ovf || w_fast_mul;
        w_fast_res = 32'd0;
        if (w_div0) begin
            if ((bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU)) begin
                w_fast_res = 32'hFFFF_FFFF;
            end else begin
                w_fast_res = bus.reg1_i;
            end
        end else if (w_ovf) begin
            if (bus.aluop_i == OP_DIV) begin
                w_fast_res = 32'h8000_0000;
            end else begin
                w_fast_res = 32'd0;
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            if (bus.aluop_i == OP_MUL) begin
                w_fast_res = w_fast_prod[31:0];
            end else begin
                w_fast_res = w_fast_prod[63:32];
            end
`else
            w_fast_res = 32'd0;
`endif
        end
    end

    // One iteration step for both algorithms plus the final sign fixup and word select.
    always_comb begin
        w_busy_mul = (r_op <= OP_MULHU);
        w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
        w_mul_nxt  = {w_mul_sum, r_acc[31:1]};
        // Top bit of the 33-bit difference doubles as the borrow: the
        // shifted remainder is below 2*divisor, so a non-negative result
        // never reaches bit 32.
        w_rem_sh   = r_acc[63:31];
        w_trial    = w_rem_sh - {1'b0, r_opd};
        w_div_nxt  = w_trial[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                 : {w_trial[31:0],  r_acc[30:0], 1'b1};
        w_acc_nxt  = w_busy_mul ? w_mul_nxt : w_div_nxt;
        w_prod_fix = r_neg_q ? (64'd0 - w_mul_nxt) : w_mul_nxt;
        w_quo_fix  = r_neg_q ? (32'd0 - w_div_nxt[31:0]) : w_div_nxt[31:0];
        w_rem_fix  = r_neg_r ? (32'd0 - w_div_nxt[63:32]) : w_div_nxt[63:32];
        case (r_op)
            OP_MUL:                         w_final = w_prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   w_final = w_prod_fix[63:32];
            OP_DIV, OP_DIVU:                w_final = w_quo_fix;
            default:                        w_final = w_rem_fix;
        endcase
    end

    // Stall request: held through the whole operation, dropped at once on flush or reset.
    always_comb begin
        w_stall = 1'b0;
        if (rst) begin
            w_stall = 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  w_stall = w_is_m && rdy && !flush_i;
                S_BUSY:  w_stall = !(flush_i && rdy);
                S_DONE:  w_stall = 1'b0;
                default: w_stall = 1'b0;
            endcase
        end
    end

    // Control FSM and datapath registers: reset > freeze on !rdy > flush > normal flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_op     <= 6'd0;
            r_wd     <= 5'd0;
            r_wreg   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opd    <= 32'd0;
            r_acc    <= 64'd0;
            r_valid  <= 1'b0;
            r_result <= 32'd0;
            r_wd_o   <= 5'd0;
            r_wreg_o <= 1'b0;
        end else if (rdy) begin
            if (flush_i) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_cnt   <= 6'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_valid <= 1'b0;
                        if (w_is_m) begin
                            r_op    <= bus.aluop_i;
                            r_wd    <= bus.wd_i;
                            r_wreg  <= bus.wreg_i;
                            r_neg_q <= w_sgn_a ^ w_sgn_b;
                            r_neg_r <= w_sgn_a;
                            r_cnt   <= 6'd0;
                            if (w_fast) begin
                                r_state  <= S_DONE;
                                r_valid  <= 1'b1;
                                r_result <= w_fast_res;
                                r_wd_o   <= bus.wd_i;
                                r_wreg_o <= bus.wreg_i;
                            end else begin
                                r_state <= S_BUSY;
                                if (w_is_mul) begin
                                    r_acc <= {32'd0, w_mag_b};
                                    r_opd <= w_mag_a;
                                end else begin
                                    r_acc <= {32'd0, w_mag_a};
                                    r_opd <= w_mag_b;
                                end
                            end
                        end
                    end
                    S_BUSY: begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= w_final;
                            r_wd_o   <= r_wd;
                            r_wreg_o <= r_wreg;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stall_req_o = w_stall;
    assign bus.valid_o     = r_valid;
    assign bus.result_o    = r_result;
    assign bus.wd_o        = r_wd_o;
    assign bus.wreg_o      = r_wreg_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table vectors, hand-written flush/rdy/reset sequences and
// randomized operations checked against a plain-arithmetic RV32M model.
module tb_ex_muldiv;
    localparam logic [5:0] OP_MUL = 6'd40, OP_MULH = 6'd41, OP_MULHSU = 6'd42, OP_MULHU = 6'd43;
    localparam logic [5:0] OP_DIV = 6'd44, OP_DIVU = 6'd45, OP_REM = 6'd46, OP_REMU = 6'd47;
    localparam logic [5:0] OP_NOP = 6'd1;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst, rdy, flush_i;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_muldiv_if bus ();
    ex_muldiv dut (.clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural RV32M result, straight from the ISA definition.
    function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'sd0;
        r  = 32'd0;
        case (op)
            OP_MUL:    begin p = sa * sb; r = p[31:0];  end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
            OP_DIV:    r = (b == 32'd0) ? 32'hFFFF_FFFF :
                           ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'($signed(a) / $signed(b)));
            OP_DIVU:   r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    r = (b == 32'd0) ? a :
                           ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(a) % $signed(b)));
            OP_REMU:   r = (b == 32'd0) ? a : a % b;
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op <= OP_MULHU) return MUL_LAT;
        if (b == 32'd0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present one op as ID/EX would (held while stalled) and observe it to completion.
    task automatic exec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg, input int drop_at, input int drop_len,
                        output logic [31:0] res, output int lat, output int nstall,
                        output logic [4:0] wdo, output logic wrego, output int vbad);
        lat = -1; nstall = 0; vbad = 0; res = 32'd0; wdo = 5'd0; wrego = 1'b0;
        @(negedge clk);
        bus.aluop_i = op; bus.reg1_i = a; bus.reg2_i = b; bus.wd_i = wd; bus.wreg_i = wreg;
        rdy = 1'b1;
        #1;
        if (bus.stall_req_o) nstall++;
        if (bus.valid_o) vbad++;
        for (int cyc = 1; cyc < 120; cyc++) begin
            @(negedge clk);
            rdy = !((cyc >= drop_at) && (cyc < drop_at + drop_len));
            #1;
            if (bus.stall_req_o) nstall++;
            if (bus.valid_o) begin
                lat = cyc; res = bus.result_o; wdo = bus.wd_o; wrego = bus.wreg_o;
                break;
            end
        end
        @(negedge clk);
        bus.aluop_i = OP_NOP; rdy = 1'b1;
        #1;
        if (bus.valid_o) vbad++;
    endtask

    logic [31:0] res, a, b;
    logic [5:0]  op;
    logic [4:0]  wdo;
    logic        wrego;
    int          lat, nstall, vbad, vseen, exp_lat;

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{OP_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[14] = '{OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT};

        // Reset with an M op already on the bus: no stall, outputs cleared.
        rst = 1'b1; rdy = 1'b1; flush_i = 1'b0;
        bus.aluop_i = OP_MUL; bus.reg1_i = 32'd7; bus.reg2_i = 32'd3; bus.wd_i = 5'd5; bus.wreg_i = 1'b1;
        @(negedge clk); #1;
        chk("rst_stall", {31'd0, bus.stall_req_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_wd", {27'd0, bus.wd_o}, 32'd0);
        chk("rst_wreg", {31'd0, bus.wreg_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.aluop_i = OP_NOP;
        #1;
        chk("nop_stall", {31'd0, bus.stall_req_o}, 32'd0);

        // aluops just outside the M range are ignored.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.aluop_i = (k == 0) ? 6'd39 : 6'd48;
            #1;
            chk($sformatf("nonm%0d_stall", k), {31'd0, bus.stall_req_o}, 32'd0);
            @(negedge clk); #1;
            chk($sformatf("nonm%0d_valid", k), {31'd0, bus.valid_o}, 32'd0);
        end
        @(negedge clk); bus.aluop_i = OP_NOP;

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            exec(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), (i % 2) == 1, 0, 0, res, lat, nstall, wdo, wrego, vbad);
            chk($sformatf("vec%0d_res", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_stall", i), 32'(nstall), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_wd", i), {27'd0, wdo}, {27'd0, 5'(i)});
            chk($sformatf("vec%0d_wreg", i), {31'd0, wrego}, {31'd0, (i % 2) == 1});
            chk($sformatf("vec%0d_pulse", i), 32'(vbad), 32'd0);
        end

        // Flush a DIVU at cycle 10: stall drops that cycle, no result ever appears.
        @(negedge clk);
        bus.aluop_i = OP_DIVU; bus.reg1_i = 32'd1000; bus.reg2_i = 32'd3; bus.wd_i = 5'd7; bus.wreg_i = 1'b1;
        #1;
        chk("flush_stall0", {31'd0, bus.stall_req_o}, 32'd1);
        vseen = 0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            @(negedge clk); #1;
            if (bus.valid_o) vseen++;
        end
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_stall10", {31'd0, bus.stall_req_o}, 32'd0);
        if (bus.valid_o) vseen++;
        @(negedge clk);
        flush_i = 1'b0; bus.aluop_i = OP_NOP;
        #1;
        if (bus.valid_o) vseen++;
        chk("flush_novalid", 32'(vseen), 32'd0);
        exec(OP_MUL, 32'd3, 32'd4, 5'd9, 1'b1, 0, 0, res, lat, nstall, wdo, wrego, vbad);
        chk("postflush_res", res, 32'd12);
        chk("postflush_lat", 32'(lat), 32'(MUL_LAT));
        chk("postflush_stall", 32'(nstall), 32'(MUL_LAT));

        // rdy low for 5 cycles from cycle 8 of a MUL: everything freezes.
        exp_lat = (MUL_LAT == 33) ? 38 : 1;
        exec(OP_MUL, 32'd12345, 32'd6789, 5'd11, 1'b1, 8, 5, res, lat, nstall, wdo, wrego, vbad);
        chk("rdy_res", res, ref_res(OP_MUL, 32'd12345, 32'd6789));
        chk("rdy_lat", 32'(lat), 32'(exp_lat));
        chk("rdy_stall", 32'(nstall), 32'(exp_lat));

        // Reset at cycle 20 of a DIVU, then confirm the unit restarts from IDLE.
        @(negedge clk);
        bus.aluop_i = OP_DIVU; bus.reg1_i = 32'd50000; bus.reg2_i = 32'd7; bus.wd_i = 5'd3; bus.wreg_i = 1'b1;
        for (int cyc = 1; cyc < 20; cyc++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_stall", {31'd0, bus.stall_req_o}, 32'd0);
        @(negedge clk); #1;
        chk("rstmid_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rstmid_result", bus.result_o, 32'd0);
        chk("rstmid_wreg", {31'd0, bus.wreg_o}, 32'd0);
        rst = 1'b0; bus.aluop_i = OP_NOP;
        #1;
        chk("rstmid_idle_stall", {31'd0, bus.stall_req_o}, 32'd0);
        exec(OP_DIVU, 32'd50000, 32'd7, 5'd3, 1'b1, 0, 0, res, lat, nstall, wdo, wrego, vbad);
        chk("postrst_res", res, 32'd7142);
        chk("postrst_lat", 32'(lat), 32'd33);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = OP_MUL + 6'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
                default: ;
            endcase
            exec(op, a, b, 5'($urandom_range(0, 31)), 1'b1, 0, 0, res, lat, nstall, wdo, wrego, vbad);
            chk($sformatf("rnd%0d_op%0d_res", i, op), res, ref_res(op, a, b));
            chk($sformatf("rnd%0d_op%0d_lat", i, op), 32'(lat), 32'(ref_lat(op, a, b)));
            chk($sformatf("rnd%0d_pulse", i), 32'(vbad), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
